// File: rtl/conv_stride_relu.sv
// conv_stride_relu: streamed strided valid-mode 2D convolution with optional ReLU and an output FIFO.
module conv_stride_relu #(
    parameter int INW = 12,
    parameter int R = 9,
    parameter int C = 8,
    parameter int MAXK = 5,
    parameter int MAXS = 3,
    parameter int FIFO_DEPTH = C - 1,
    localparam int OUTW = $clog2(MAXK * MAXK * 2 ** (2 * INW - 2) + 2 ** (INW - 1)) + 1,
    localparam int K_BITS = $clog2(MAXK + 1),
    localparam int S_BITS = $clog2(MAXS + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [INW-1:0]           INPUT_TDATA,
    input  logic                     INPUT_TVALID,
    input  logic [K_BITS+S_BITS+1:0] INPUT_TUSER,
    output logic                     INPUT_TREADY,
    output logic [OUTW-1:0]          OUTPUT_TDATA,
    output logic                     OUTPUT_TVALID,
    output logic                     OUTPUT_TLAST,
    input  logic                     OUTPUT_TREADY
);
    localparam int XN = R * C;
    localparam int WN = MAXK * MAXK;
    localparam int XA = $clog2(XN);
    localparam int WA = $clog2(WN);
    localparam int FA = $clog2(FIFO_DEPTH);
    localparam int CB = $clog2(FIFO_DEPTH + 1);
    localparam int RB = $clog2(R + 1);
    localparam int CW = $clog2(C + 1);
    localparam logic [2:0] LOAD = 3'd0, COMPUTE = 3'd1, FLUSH = 3'd2, WRITE = 3'd3, DONE = 3'd4;
    localparam logic [1:0] PW = 2'd0, PB = 2'd1, PX = 2'd2;

    logic [2:0] state;
    logic [1:0] ph, cur_ph;
    logic [XA-1:0] idx, cur_idx, xa;
    logic [WA-1:0] wa;
    logic first, w_valid, rdy, relu_r, fl, v1, f1;
    logic [K_BITS-1:0] k_r, cur_k, ki, kj;
    logic [S_BITS-1:0] s_r;
    logic [RB-1:0] wr;
    logic [CW-1:0] wc;
    logic signed [INW-1:0] b_r, x_q, w_q;
    logic signed [2*INW-1:0] prod;
    logic signed [OUTW-1:0] acc, res;
    logic signed [INW-1:0] xm [XN];
    logic signed [INW-1:0] wm [WN];
    logic [OUTW:0] fm [FIFO_DEPTH];
    logic [FA-1:0] wp, rp;
    logic [CB-1:0] cnt;
    logic beat, ld_new, last_w, last_x, last_k, last_c, last_r, full, push, pop;

    // The first beat of a job decides its phase: a missing weight set forces a weight load.
    always_comb begin
        beat = INPUT_TVALID && INPUT_TREADY;
        ld_new = INPUT_TUSER[K_BITS] || !w_valid;
        cur_ph = first ? (ld_new ? PW : PX) : ph;
        cur_k = first && ld_new ? INPUT_TUSER[K_BITS-1:0] : k_r;
        cur_idx = first ? '0 : idx;
        last_w = 32'(cur_idx) == 32'(cur_k) * 32'(cur_k) - 1;
        last_x = 32'(cur_idx) == XN - 1;
        last_k = ki == k_r - K_BITS'(1) && kj == k_r - K_BITS'(1);
        last_c = (32'(wc) + 1) * 32'(s_r) + 32'(k_r) > C;
        last_r = (32'(wr) + 1) * 32'(s_r) + 32'(k_r) > R;
        xa = XA'((32'(wr) * 32'(s_r) + 32'(ki)) * C + 32'(wc) * 32'(s_r) + 32'(kj));
        wa = WA'(32'(ki) * 32'(k_r) + 32'(kj));
        prod = x_q * w_q;
        res = relu_r && acc[OUTW-1] ? '0 : acc;
        full = 32'(cnt) == FIFO_DEPTH;
        push = state == WRITE && !full;
        pop = cnt != '0 && OUTPUT_TREADY;
    end

    assign INPUT_TREADY = rdy && state == LOAD;
    assign OUTPUT_TVALID = cnt != '0;
    assign {OUTPUT_TLAST, OUTPUT_TDATA} = OUTPUT_TVALID ? fm[rp] : '0;

    always_ff @(posedge clk) begin
        if (beat && cur_ph == PW) wm[WA'(cur_idx)] <= INPUT_TDATA;
        if (beat && cur_ph == PX) xm[cur_idx] <= INPUT_TDATA;
        if (push) fm[wp] <= {last_r && last_c, res};
        x_q <= xm[xa];
        w_q <= wm[wa];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= LOAD;
            ph <= PW;
            idx <= '0;
            first <= 1'b1;
            w_valid <= 1'b0;
            rdy <= 1'b0;
            fl <= 1'b0;
            v1 <= 1'b0;
            f1 <= 1'b0;
            acc <= '0;
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            rdy <= 1'b1;
            v1 <= state == COMPUTE;
            f1 <= state == COMPUTE && ki == '0 && kj == '0;
            if (v1) acc <= f1 ? OUTW'(b_r) + OUTW'(prod) : acc + OUTW'(prod);
            if (pop) rp <= rp == FA'(FIFO_DEPTH - 1) ? '0 : rp + FA'(1);
            if (push) wp <= wp == FA'(FIFO_DEPTH - 1) ? '0 : wp + FA'(1);
            cnt <= cnt + CB'(push) - CB'(pop);
            case (state)
                LOAD: if (beat) begin
                    first <= 1'b0;
                    if (first) begin
                        relu_r <= INPUT_TUSER[K_BITS+S_BITS+1];
                        s_r <= INPUT_TUSER[K_BITS+S_BITS:K_BITS+1] == '0 ? S_BITS'(1) : INPUT_TUSER[K_BITS+S_BITS:K_BITS+1];
                        k_r <= cur_k;
                    end
                    ph <= cur_ph;
                    idx <= cur_idx + XA'(1);
                    if (cur_ph == PW && last_w) begin
                        ph <= PB;
                        idx <= '0;
                    end
                    if (cur_ph == PB) begin
                        b_r <= INPUT_TDATA;
                        w_valid <= 1'b1;
                        ph <= PX;
                        idx <= '0;
                    end
                    if (cur_ph == PX && last_x) begin
                        state <= COMPUTE;
                        ki <= '0;
                        kj <= '0;
                        wr <= '0;
                        wc <= '0;
                    end
                end
                COMPUTE: begin
                    kj <= kj == k_r - K_BITS'(1) ? '0 : kj + K_BITS'(1);
                    if (kj == k_r - K_BITS'(1)) ki <= last_k ? '0 : ki + K_BITS'(1);
                    if (last_k) begin
                        state <= FLUSH;
                        fl <= 1'b0;
                    end
                end
                FLUSH: begin
                    fl <= 1'b1;
                    if (fl) state <= WRITE;
                end
                WRITE: if (!full) begin
                    wc <= last_c ? '0 : wc + CW'(1);
                    if (last_c) wr <= wr + RB'(1);
                    state <= last_c && last_r ? DONE : COMPUTE;
                end
                DONE: begin
                    state <= LOAD;
                    first <= 1'b1;
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_stride_relu.sv
// tb_conv_stride_relu: table vectors, directed corner sequences and randomized jobs against a reference model.
module tb_conv_stride_relu;
    localparam int R = 9, C = 8, OW = 28;

    logic clk = 1'b0, reset = 1'b0;
    logic [11:0] INPUT_TDATA = '0;
    logic INPUT_TVALID = 1'b0;
    logic [6:0] INPUT_TUSER = '0;
    logic INPUT_TREADY;
    logic signed [OW-1:0] OUTPUT_TDATA;
    logic OUTPUT_TVALID, OUTPUT_TLAST;
    logic OUTPUT_TREADY = 1'b1;

    conv_stride_relu dut (
        .clk(clk), .reset(reset),
        .INPUT_TDATA(INPUT_TDATA), .INPUT_TVALID(INPUT_TVALID), .INPUT_TUSER(INPUT_TUSER), .INPUT_TREADY(INPUT_TREADY),
        .OUTPUT_TDATA(OUTPUT_TDATA), .OUTPUT_TVALID(OUTPUT_TVALID), .OUTPUT_TLAST(OUTPUT_TLAST), .OUTPUT_TREADY(OUTPUT_TREADY)
    );

    typedef struct {
        bit relu; int s; bit nw; int k; int wv; int bv; int xv; int exp_n; longint exp_v;
    } vec_t;
    vec_t tab[7];

    int checks = 0, errors = 0, cyc = 0, ready_mode = 0;
    bit gaps = 0;
    longint got_d[$], exp_d[$];
    bit got_l[$];
    int got_t[$];
    logic signed [11:0] jw[25], jx[72], jb, mw[25], mb;
    int mk = 0;
    bit mwv = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (OUTPUT_TVALID && OUTPUT_TREADY) begin
        got_d.push_back(longint'(OUTPUT_TDATA));
        got_l.push_back(OUTPUT_TLAST);
        got_t.push_back(cyc);
    end

    initial forever begin
        @(posedge clk);
        #1;
        OUTPUT_TREADY = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'b0 : 1'($urandom_range(0, 1));
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Called at 1 time unit after a rising edge; returns at the same phase after the transfer edge.
    task automatic send_beat(input logic [11:0] d, input logic [6:0] u);
        int t = 0;
        if (gaps && $urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
        end
        INPUT_TDATA = d;
        INPUT_TUSER = u;
        INPUT_TVALID = 1'b1;
        @(negedge clk);
        while (!INPUT_TREADY && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            $display("FAIL input_timeout: got tready 0 want 1");
            $fatal(1, "input stalled");
        end
        @(posedge clk);
        #1;
        INPUT_TVALID = 1'b0;
    endtask

    task automatic send_job(input bit relu, input int s, input bit nw, input int k);
        bit ld;
        int se;
        logic [6:0] u;
        ld = nw || !mwv;
        if (ld) begin
            mk = k;
            mb = jb;
            foreach (jw[i]) mw[i] = jw[i];
            mwv = 1;
        end
        se = s == 0 ? 1 : s;
        exp_d.delete();
        for (int r = 0; r * se + mk <= R; r++)
            for (int c = 0; c * se + mk <= C; c++) begin
                longint a;
                a = longint'(mb);
                for (int i = 0; i < mk; i++)
                    for (int j = 0; j < mk; j++)
                        a += longint'(jx[(r * se + i) * C + c * se + j]) * longint'(mw[i * mk + j]);
                if (relu && a < 0) a = 0;
                exp_d.push_back(a);
            end
        got_d.delete();
        got_l.delete();
        got_t.delete();
        u = {relu, s[1:0], nw, k[2:0]};
        @(posedge clk);
        #1;
        if (ld) begin
            for (int i = 0; i < mk * mk; i++) send_beat(jw[i], i == 0 ? u : 7'($urandom));
            send_beat(jb, 7'($urandom));
        end
        for (int i = 0; i < R * C; i++) send_beat(jx[i], (i == 0 && !ld) ? u : 7'($urandom));
        chk("tready_drop", INPUT_TREADY, 0);
    endtask

    task automatic check_results(input string tag, input bit timing);
        int t = 0, bad = 0, badl = 0, badt = 0, fb = -1;
        while (got_d.size() < exp_d.size() && t < 20000) begin
            @(negedge clk);
            t++;
        end
        repeat (40) @(negedge clk);
        chk({tag, "_count"}, got_d.size(), exp_d.size());
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            if (got_d[i] != exp_d[i]) begin
                bad++;
                if (fb < 0) fb = i;
            end
            if (got_l[i] != (i == exp_d.size() - 1)) badl++;
            if (timing && i > 0 && got_t[i] - got_t[i-1] != mk * mk + 3) badt++;
        end
        if (fb >= 0) $display("first bad %s index %0d got %0d want %0d", tag, fb, got_d[fb], exp_d[fb]);
        chk({tag, "_bad_values"}, bad, 0);
        chk({tag, "_bad_tlast"}, badl, 0);
        if (timing) chk({tag, "_bad_intervals"}, badt, 0);
    endtask

    task automatic rand_data();
        foreach (jw[i]) jw[i] = 12'($urandom);
        foreach (jx[i]) jx[i] = 12'($urandom);
        jb = 12'($urandom);
    endtask

    initial begin
        tab[0] = '{0, 1, 1, 3, 1, 2, 1, 42, 11};
        tab[1] = '{0, 2, 1, 3, 1, 2, 1, 12, 11};
        tab[2] = '{0, 1, 1, 3, -1, 0, 1, 42, -9};
        tab[3] = '{1, 1, 1, 3, -1, 0, 1, 42, 0};
        tab[4] = '{0, 1, 1, 5, -2048, -2048, -2048, 20, 104855552};
        tab[5] = '{0, 3, 1, 1, 3, -5, 2, 9, 1};
        tab[6] = '{0, 0, 0, 5, 7, 7, -1, 72, -8};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready", INPUT_TREADY, 0);
        chk("rst_tvalid", OUTPUT_TVALID, 0);
        chk("rst_tdata", OUTPUT_TDATA, 0);
        chk("rst_tlast", OUTPUT_TLAST, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_tready_rise", INPUT_TREADY, 1);

        for (int v = 0; v < 7; v++) begin
            foreach (jw[i]) jw[i] = 12'(tab[v].wv);
            foreach (jx[i]) jx[i] = 12'(tab[v].xv);
            jb = 12'(tab[v].bv);
            send_job(tab[v].relu, tab[v].s, tab[v].nw, tab[v].k);
            exp_d.delete();
            repeat (tab[v].exp_n) exp_d.push_back(tab[v].exp_v);
            check_results($sformatf("vec%0d", v), 1);
        end

        foreach (jw[i]) jw[i] = 12'sd1;
        foreach (jx[i]) jx[i] = 12'(i);
        jb = 12'sd2;
        send_job(0, 2, 1, 3);
        check_results("ramp_s2", 0);
        chk("ramp_s2_r1c2", got_d.size() > 5 ? got_d[5] : -1, 263);

        ready_mode = 1;
        rand_data();
        send_job(0, 1, 1, 3);
        repeat (200) @(negedge clk);
        chk("stall_tready", INPUT_TREADY, 0);
        chk("stall_tvalid", OUTPUT_TVALID, 1);
        chk("stall_no_output", got_d.size(), 0);
        ready_mode = 0;
        check_results("stall", 0);
        begin
            int run = got_t.size() > 0 ? 1 : 0;
            while (run < got_t.size() && got_t[run] == got_t[0] + run) run++;
            chk("stall_burst_len", run, 8);
        end

        ready_mode = 1;
        rand_data();
        send_job(0, 1, 1, 3);
        repeat (40) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        mwv = 0;
        chk("midrst_tvalid", OUTPUT_TVALID, 0);
        chk("midrst_tready", INPUT_TREADY, 0);
        ready_mode = 0;
        @(posedge clk);
        #1;
        chk("midrst_tready_rise", INPUT_TREADY, 1);
        rand_data();
        send_job(0, 2, 0, 2);
        check_results("promote", 1);

        for (int n = 0; n < 10; n++) begin
            int k, s;
            bit relu, nw;
            k = $urandom_range(1, 5);
            s = $urandom_range(0, 3);
            relu = 1'($urandom_range(0, 1));
            nw = $urandom_range(0, 3) != 0;
            ready_mode = n % 2 == 1 ? 2 : 0;
            gaps = n % 3 == 0;
            rand_data();
            send_job(relu, s, nw, k);
            check_results($sformatf("rand%0d", n), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
